range_scan_ctrl: RTL and testbench

//   Sequencer and address arbiter for the Collatz range engine (range). On a run request it pulses go,

---
 rtl/range_scan_ctrl.sv | 109 ++++++++++
 tb/tb_range_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/range_scan_ctrl.sv
// Sequencer and address arbiter for the Collatz range engine: starts a run,
// waits for the engine to finish, then sweeps its RAM for max/index/sum.
module range_scan_ctrl #(
  parameter int unsigned RAM_WORDS     = 256,
  parameter int unsigned RAM_ADDR_BITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic [31:0]                   base,
  input  logic [RAM_ADDR_BITS-1:0]      sel_n,
  output logic                          go,
  output logic [31:0]                   start,
  input  logic                          done,
  output logic [RAM_ADDR_BITS-1:0]      n,
  input  logic [15:0]                   count,
  output logic                          busy,
  output logic                          result_valid,
  output logic [15:0]                   max_count,
  output logic [RAM_ADDR_BITS-1:0]      max_index,
  output logic [16+RAM_ADDR_BITS-1:0]   sum_count
);

  typedef enum logic [2:0] {
    IDLE, GO, ARM, WAIT, SCAN, DRAIN, DONE
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                     state, state_nxt;
  logic                       accept;
  logic [RAM_ADDR_BITS-1:0]   addr;
  logic [RAM_ADDR_BITS-1:0]   pend_idx;
  logic                       pend_valid;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (req) begin
        accept    = 1'b1;
        state_nxt = GO;
      end
      GO:      state_nxt = ARM;
      // ARM exists so a done level left over from the previous run is never taken as completion
      ARM:     state_nxt = WAIT;
      WAIT:    if (done) state_nxt = SCAN;
      SCAN:    if (addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    n = sel_n;
    if (state == SCAN) n = addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go           <= 1'b0;
      start        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      max_count    <= '0;
      max_index    <= '0;
      sum_count    <= '0;
      addr         <= '0;
      pend_idx     <= '0;
      pend_valid   <= 1'b0;
    end else begin
      go         <= (state_nxt == GO);
      pend_valid <= (state == SCAN);
      pend_idx   <= addr;

      if (accept) begin
        start        <= base;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        max_count    <= '0;
        max_index    <= '0;
        sum_count    <= '0;
      end

      if (state == DRAIN) begin
        busy         <= 1'b0;
        result_valid <= 1'b1;
      end

      if (state == WAIT && done) addr <= '0;
      else if (state == SCAN)    addr <= addr + RAM_ADDR_BITS'(1);

      // count arriving now belongs to the address issued one cycle earlier
      if (pend_valid) begin
        sum_count <= sum_count + (16 + RAM_ADDR_BITS)'(count);
        if (count > max_count) begin
          max_count <= count;
          max_index <= pend_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Directed bench for range_scan_ctrl with a small behavioural range engine
// (8-word RAM, done 20 cycles after go, stale done held briefly after go).
module tb_range_scan_ctrl;

  localparam int unsigned RW = 8;
  localparam int unsigned AB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [31:0]   base;
  logic [AB-1:0] sel_n;
  logic          go;
  logic [31:0]   start;
  logic          done = 1'b0;
  logic [AB-1:0] n;
  logic [15:0]   count = '0;
  logic          busy;
  logic          result_valid;
  logic [15:0]   max_count;
  logic [AB-1:0] max_index;
  logic [AB+15:0] sum_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [RW];
  int          gocnt = 0;

  range_scan_ctrl #(.RAM_WORDS(RW), .RAM_ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .req(req), .base(base), .sel_n(sel_n),
    .go(go), .start(start), .done(done), .n(n), .count(count),
    .busy(busy), .result_valid(result_valid), .max_count(max_count),
    .max_index(max_index), .sum_count(sum_count)
  );

  always #5 clk = ~clk;

  // range engine model: sync RAM read; done drops two cycles after go, rises 20 after go
  always @(posedge clk) begin
    count <= mem[n];
    if (go) gocnt <= 20;
    else if (gocnt != 0) gocnt <= gocnt - 1;
    if (gocnt == 20) done <= 1'b0;
    if (gocnt == 1)  done <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [15:0] c0, c1, c2, c3, c4, c5, c6, c7);
    mem[0] = c0; mem[1] = c1; mem[2] = c2; mem[3] = c3;
    mem[4] = c4; mem[5] = c5; mem[6] = c6; mem[7] = c7;
  endtask

  // full run: req accepted in cycle 0, sampling at negedge of each following cycle
  task automatic run(input logic [31:0] b, input bit extra_req, input bit want_stale,
                     input logic [15:0] exp_max, input logic [AB-1:0] exp_idx,
                     input logic [31:0] exp_sum);
    int  d = -1;
    int  r = -1;
    int  gos = 0;
    bit  seen_low = 1'b0;
    @(negedge clk);
    base = b;
    req  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (go) gos++;
      if (cyc == 1) begin
        check("start_latched", start, b);
        check("busy_after_req", 32'(busy), 1);
      end
      if (want_stale && cyc == 2) check("stale_done_in_arm", 32'(done), 1);
      if (cyc == 10) check("n_sel_in_wait", 32'(n), 32'(sel_n));
      if (!done) seen_low = 1'b1;
      if (seen_low && done && d < 0) d = cyc;
      if (d >= 0 && cyc >= d + 1 && cyc <= d + int'(RW))
        check("n_scan_step", 32'(n), 32'(cyc - d - 1));
      if (result_valid) begin
        r = cyc;
        break;
      end
      @(negedge clk);
      req = extra_req && (cyc + 1 == 10 || (d >= 0 && cyc + 1 == d + 3));
    end
    req = 1'b0;
    check("run_completes", 32'(r > 0 && d > 0), 1);
    check("rv_latency", 32'(r - d), RW + 2);
    check("go_pulses", 32'(gos), 1);
    check("busy_done", 32'(busy), 0);
    check("max_count", 32'(max_count), 32'(exp_max));
    check("max_index", 32'(max_index), 32'(exp_idx));
    check("sum_count", 32'(sum_count), exp_sum);
    @(negedge clk);
    check("n_sel_in_done", 32'(n), 32'(sel_n));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_go"}, 32'(go), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_max"}, 32'(max_count), 0);
    check({tag, "_idx"}, 32'(max_index), 0);
    check({tag, "_sum"}, 32'(sum_count), 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_n"}, 32'(n), 32'(sel_n));
  endtask

  initial begin
    bit seen_low;
    int d;
    reset = 1'b1;
    req   = 1'b0;
    base  = '0;
    sel_n = 3'd5;
    load_mem(16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3);
    repeat (2) @(negedge clk);
    check_cleared("reset");
    check("n_sel_idle", 32'(n), 5);
    reset = 1'b0;

    // reset asserted asynchronously in the middle of a sweep
    @(negedge clk);
    base = 32'd9;
    req  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    seen_low = 1'b0;
    d = -1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (!done) seen_low = 1'b1;
      if (seen_low && done && d < 0) d = cyc;
      if (d >= 0 && cyc == d + 5) break;
      @(negedge clk);
    end
    check("abort_reached_scan", 32'(d > 0), 1);
    check("abort_scan_partial", 32'(max_count != 0), 1);
    #2 reset = 1'b1;
    #1 check_cleared("async_reset");
    @(negedge clk);
    check_cleared("reset_next");
    reset = 1'b0;
    @(negedge clk);

    run(32'd1, 1'b0, 1'b0, 16'd16, 3'd6, 32'd42);

    load_mem(16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
    run(32'd77, 1'b0, 1'b1, 16'd5, 3'd0, 32'd40);

    load_mem(16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3);
    run(32'd1, 1'b1, 1'b1, 16'd16, 3'd6, 32'd42);

    check("done_stale_before_req", 32'(done), 1);
    sel_n = 3'd2;
    run(32'hDEAD_BEEF, 1'b0, 1'b1, 16'd16, 3'd6, 32'd42);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
